pmod_kypd_scanner: RTL and testbench

- Parametrised matrix-keypad scanner for the PmodKYPD and larger NUM_ROWS x NUM_COLS matrices; replaces the fixed 4x4, 1 ms-per-column decoder.
- Drives one active-low column at a time, synchronises the active-low row inputs and captures a full-frame key bitmap.
- Debounces whole frames and publishes a stable bitmap, the lowest-index key code, press/release pulses and a multi-key flag.
- Sits between the Pmod pins and display/control logic, all on the 100 MHz system clock.

---
 rtl/pmod_kypd_scanner.sv | 239 +++++++++++++++++++++++
 tb/tb_pmod_kypd_scanner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_kypd_scanner.sv
// Matrix keypad scanner with frame debouncing.
//
// Drives one active-low column at a time and synchronises the active-low rows.
// Each column's rows are sampled once, after the column has had time to settle.
// One sample per column builds a full raw key bitmap (a frame).
// The stable bitmap only updates after DEBOUNCE_FRAMES consecutive identical frames.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   row           keypad rows, active low, asynchronous to clk
//   col           keypad columns, one bit low while scanning
//   key_state     debounced bitmap, bit r*NUM_COLS+c set when pressed
//   key_valid     at least one key pressed
//   key_code      code of lowest-index pressed key (holds when none pressed)
//   multi_key     two or more keys pressed
//   press_pulse   key_valid rose, or key_code changed while valid
//   release_pulse key_valid fell
//   frame_done    one-cycle pulse after each raw frame completes
module pmod_kypd_scanner #(
    parameter int unsigned NUM_ROWS        = 4,
    parameter int unsigned NUM_COLS        = 4,
    parameter int unsigned SCAN_TICKS      = 100000,
    parameter int unsigned SETTLE_TICKS    = 8,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned HEX_MAP         = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_ROWS-1:0]             row,
    output logic [NUM_COLS-1:0]             col,
    output logic [NUM_ROWS*NUM_COLS-1:0]    key_state,
    output logic                            key_valid,
    output logic [((NUM_ROWS*NUM_COLS > 16) ? $clog2(NUM_ROWS*NUM_COLS) : 4)-1:0] key_code,
    output logic                            multi_key,
    output logic                            press_pulse,
    output logic                            release_pulse,
    output logic                            frame_done
);

    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int unsigned CODE_W   = (NUM_KEYS > 16) ? $clog2(NUM_KEYS) : 4;
    localparam int unsigned TICK_W   = $clog2(SCAN_TICKS);
    localparam int unsigned COL_W    = $clog2(NUM_COLS);

    localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(SCAN_TICKS - 1);
    localparam logic [TICK_W-1:0]   TICK_SETTLE = TICK_W'(SETTLE_TICKS);
    localparam logic [COL_W-1:0]    COL_LAST    = COL_W'(NUM_COLS - 1);
    localparam logic [3:0]          DB_MAX      = 4'(DEBOUNCE_FRAMES);
    localparam logic [NUM_COLS-1:0] COL_ONE     = NUM_COLS'(1);
    localparam logic [NUM_KEYS-1:0] KEY_ONE     = NUM_KEYS'(1);
    localparam bit USE_LEGEND = (HEX_MAP == 1) && (NUM_ROWS == 4) && (NUM_COLS == 4);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StHold} state_e;

    state_e                state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [COL_W-1:0]      col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0]   col_q, col_d;
    logic [NUM_ROWS-1:0]   row_m_q, row_s_q;
    logic [NUM_KEYS-1:0]   raw_q, raw_d;
    logic [NUM_KEYS-1:0]   prev_q, prev_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]   key_state_q, key_state_d;
    logic                  frame_end;
    logic                  frame_done_q;
    logic                  key_valid_q, key_valid_d;
    logic                  multi_q, multi_d;
    logic [CODE_W-1:0]     key_code_q, key_code_d;
    logic [CODE_W-1:0]     low_idx;
    logic                  press_q, press_d;
    logic                  release_q, release_d;

    // PmodKYPD silkscreen legend, row-major from r0c0.
    function automatic logic [3:0] hex_legend(input logic [3:0] idx);
        logic [3:0] val;
        val = 4'h0;
        case (idx)
            4'd0:  val = 4'h1;
            4'd1:  val = 4'h2;
            4'd2:  val = 4'h3;
            4'd3:  val = 4'hA;
            4'd4:  val = 4'h4;
            4'd5:  val = 4'h5;
            4'd6:  val = 4'h6;
            4'd7:  val = 4'hB;
            4'd8:  val = 4'h7;
            4'd9:  val = 4'h8;
            4'd10: val = 4'h9;
            4'd11: val = 4'hC;
            4'd12: val = 4'h0;
            4'd13: val = 4'hF;
            4'd14: val = 4'hE;
            4'd15: val = 4'hD;
            default: val = 4'h0;
        endcase
        return val;
    endfunction

    // Scan sequencer: tick/column counters and per-column phase.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        col_idx_d = col_idx_q;
        col_d     = col_q;
        raw_d     = raw_q;
        frame_end = 1'b0;

        unique case (state_q)
            StIdle: begin
                // First cycle out of reset: start driving column 0 with tick 0.
                tick_d    = '0;
                col_idx_d = '0;
                col_d     = ~COL_ONE;
            end
            StDrive, StSample, StHold: begin
                if (state_q == StSample) begin
                    for (int r = 0; r < NUM_ROWS; r++) begin
                        for (int c = 0; c < NUM_COLS; c++) begin
                            if (COL_W'(c) == col_idx_q) begin
                                raw_d[r*NUM_COLS + c] = ~row_s_q[r];
                            end
                        end
                    end
                end
                if (tick_q == TICK_LAST) begin
                    tick_d    = '0;
                    frame_end = (col_idx_q == COL_LAST);
                    col_idx_d = frame_end ? '0 : col_idx_q + COL_W'(1);
                    col_d     = ~(COL_ONE << col_idx_d);
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                tick_d = '0;
            end
        endcase

        if (tick_d < TICK_SETTLE) begin
            state_d = StDrive;
        end else if (tick_d == TICK_SETTLE) begin
            state_d = StSample;
        end else begin
            state_d = StHold;
        end
    end

    // Frame debounce: count consecutive identical raw frames.
    always_comb begin
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        key_state_d = key_state_q;
        if (frame_end) begin
            if (raw_q == prev_q) begin
                if (cnt_q != DB_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d  = 4'd1;
                prev_d = raw_q;
            end
            if (cnt_d == DB_MAX) begin
                key_state_d = raw_q;
            end
        end
    end

    // Lowest set bit index of the stable bitmap.
    always_comb begin
        low_idx = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (key_state_q[i]) begin
                low_idx = CODE_W'(i);
            end
        end
    end

    // Derived outputs, one cycle behind key_state.
    always_comb begin
        key_valid_d = |key_state_q;
        // Clearing the lowest set bit leaves something iff two or more are set.
        multi_d     = (key_state_q & (key_state_q - KEY_ONE)) != '0;
        key_code_d  = key_code_q;
        if (key_valid_d) begin
            key_code_d = USE_LEGEND ? CODE_W'(hex_legend(low_idx[3:0])) : low_idx;
        end
        press_d   = key_valid_d && (!key_valid_q || (key_code_d != key_code_q));
        release_d = !key_valid_d && key_valid_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tick_q       <= '0;
            col_idx_q    <= '0;
            col_q        <= '1;
            row_m_q      <= '1;
            row_s_q      <= '1;
            raw_q        <= '0;
            prev_q       <= '0;
            cnt_q        <= '0;
            key_state_q  <= '0;
            frame_done_q <= 1'b0;
            key_valid_q  <= 1'b0;
            multi_q      <= 1'b0;
            key_code_q   <= '0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            col_idx_q    <= col_idx_d;
            col_q        <= col_d;
            row_m_q      <= row;
            row_s_q      <= row_m_q;
            raw_q        <= raw_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            key_state_q  <= key_state_d;
            frame_done_q <= frame_end;
            key_valid_q  <= key_valid_d;
            multi_q      <= multi_d;
            key_code_q   <= key_code_d;
            press_q      <= press_d;
            release_q    <= release_d;
        end
    end

    assign col           = col_q;
    assign key_state     = key_state_q;
    assign key_valid     = key_valid_q;
    assign key_code      = key_code_q;
    assign multi_key     = multi_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_pmod_kypd_scanner.sv
// Bench for pmod_kypd_scanner: keypad model driving rows from the DUT columns,
// a frame-level reference model checked every cycle, and directed literal checks.
module tb_pmod_kypd_scanner;

    localparam int NC     = 4;
    localparam int SCAN   = 16;
    localparam int SETTLE = 4;
    localparam int DF     = 2;
    localparam int FRAME  = NC * SCAN;

    localparam logic [3:0] LEGEND [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] key_state;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        multi_key;
    logic        press_pulse;
    logic        release_pulse;
    logic        frame_done;

    logic [15:0] pressed = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = -1;
    bit          seen_reset = 1'b0;
    int          press_cnt = 0;
    int          release_cnt = 0;

    // Reference model state
    logic [15:0] m_ks = '0;
    logic        m_valid = 1'b0;
    logic        m_multi = 1'b0;
    logic        m_press = 1'b0;
    logic        m_release = 1'b0;
    logic [3:0]  m_code = '0;
    logic [15:0] hist[$];

    pmod_kypd_scanner #(
        .NUM_ROWS       (4),
        .NUM_COLS       (4),
        .SCAN_TICKS     (SCAN),
        .SETTLE_TICKS   (SETTLE),
        .DEBOUNCE_FRAMES(DF),
        .HEX_MAP        (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .row          (row),
        .col          (col),
        .key_state    (key_state),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .multi_key    (multi_key),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Keypad: a row reads low when any pressed key on it sits on a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = ~(|(pressed[r*4 +: 4] & ~col));
        end
    end

    // Cycle index since reset release; -1 while in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            cyc        <= -1;
            seen_reset <= 1'b1;
        end else begin
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] lowest_code(input logic [15:0] ks, input logic [3:0] hold);
        for (int i = 0; i < 16; i++) begin
            if (ks[i]) return LEGEND[i];
        end
        return hold;
    endfunction

    // True when the last DF recorded frames are identical.
    function automatic bit frames_settled();
        if (hist.size() < DF) return 1'b0;
        for (int i = 1; i < DF; i++) begin
            if (hist[hist.size() - 1 - i] != hist[hist.size() - 1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Per-cycle compare against the frame-level model.
    always @(negedge clk) begin
        logic       nv;
        logic [3:0] nc;
        logic [3:0] ecol;
        if (seen_reset) begin
            if (press_pulse) press_cnt++;
            if (release_pulse) release_cnt++;
            if (cyc < 0) begin
                chk("rst col", col, 4'hF);
                chk("rst key_state", key_state, 16'h0);
                chk("rst key_valid", key_valid, 1'b0);
                chk("rst key_code", key_code, 4'h0);
                chk("rst multi_key", multi_key, 1'b0);
                chk("rst press", press_pulse, 1'b0);
                chk("rst release", release_pulse, 1'b0);
                chk("rst frame_done", frame_done, 1'b0);
                hist.delete();
                m_ks = '0; m_valid = 1'b0; m_multi = 1'b0; m_code = '0;
                m_press = 1'b0; m_release = 1'b0;
            end else begin
                // Derived outputs follow the previous cycle's stable bitmap.
                nv        = (m_ks != '0);
                nc        = lowest_code(m_ks, m_code);
                m_press   = nv && (!m_valid || nc != m_code);
                m_release = !nv && m_valid;
                m_multi   = ($countones(m_ks) >= 2);
                m_valid   = nv;
                m_code    = nc;
                if (cyc % FRAME == 30) hist.push_back(pressed);
                if (cyc % FRAME == 0 && cyc >= FRAME && frames_settled()) m_ks = hist[hist.size()-1];
                ecol = ~(4'b0001 << ((cyc / SCAN) % NC));
                chk("col", col, ecol);
                chk("frame_done", frame_done, (cyc % FRAME == 0) && (cyc >= FRAME));
                chk("key_state", key_state, m_ks);
                chk("key_valid", key_valid, m_valid);
                chk("key_code", key_code, m_code);
                chk("multi_key", multi_key, m_multi);
                chk("press_pulse", press_pulse, m_press);
                chk("release_pulse", release_pulse, m_release);
            end
        end
    end

    task automatic wait_cycle(input int target);
        int n = 0;
        while (cyc != target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cycle", cyc, target);
    endtask

    // Advance to cycle 60 of a frame: after the last column sample, before the next frame.
    task automatic next_boundary();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc % FRAME != 60 && n < 500);
        chk("boundary", cyc % FRAME, 60);
    endtask

    task automatic set_keys(input logic [15:0] v);
        next_boundary();
        pressed = v;
    endtask

    task automatic run_frames(input int n);
        repeat (n) next_boundary();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic [15:0] cur;
        int          base;
        int          n;

        rst_n   = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle scan
        wait_cycle(0);   chk("idle col0", col, 4'b1110);
        wait_cycle(16);  chk("idle col1", col, 4'b1101);
        wait_cycle(32);  chk("idle col2", col, 4'b1011);
        wait_cycle(48);  chk("idle col3", col, 4'b0111);
        wait_cycle(64);  chk("first frame_done", frame_done, 1'b1);
        wait_cycle(65);  chk("frame_done width", frame_done, 1'b0);
        wait_cycle(128); chk("second frame_done", frame_done, 1'b1);
        chk("idle key_valid", key_valid, 1'b0);

        // r1c2 held
        base = press_cnt;
        set_keys(16'h0040);
        run_frames(3);
        chk("r1c2 key_state", key_state, 16'h0040);
        chk("r1c2 key_code", key_code, 4'h6);
        chk("r1c2 key_valid", key_valid, 1'b1);
        chk("r1c2 press once", press_cnt - base, 1);

        // Release
        base = release_cnt;
        set_keys(16'h0000);
        run_frames(3);
        chk("release key_valid", key_valid, 1'b0);
        chk("release once", release_cnt - base, 1);
        chk("release code hold", key_code, 4'h6);

        // Bounce r2c1, then hold
        base = press_cnt;
        for (int i = 0; i < 5; i++) begin
            set_keys((i % 2 == 0) ? 16'h0200 : 16'h0000);
        end
        chk("bounce key_state", key_state, 16'h0000);
        run_frames(3);
        chk("bounce settled", key_state, 16'h0200);
        chk("bounce key_code", key_code, 4'h8);
        chk("bounce press once", press_cnt - base, 1);

        // Two keys
        set_keys(16'h8001);
        run_frames(3);
        chk("two key_state", key_state, 16'h8001);
        chk("two key_code", key_code, 4'h1);
        chk("two multi_key", multi_key, 1'b1);

        // Reset at tick 7 of column 2
        n = 0;
        while (cyc % FRAME != 39 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid reset point", cyc % FRAME, 39);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid rst key_state", key_state, 16'h0);
        chk("mid rst key_valid", key_valid, 1'b0);
        chk("mid rst col", col, 4'hF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart col", col, 4'b1110);
        wait_cycle(130);
        chk("reappear key_state", key_state, 16'h8001);
        chk("reappear key_valid", key_valid, 1'b1);
        chk("reappear key_code", key_code, 4'h1);

        // Random key patterns, checked by the per-cycle model
        cur = pressed;
        for (int f = 0; f < 30; f++) begin
            v = cur;
            case ($urandom_range(0, 4))
                0, 1: v = cur;
                2:    v = 16'h0000;
                3:    v = 16'(1) << $urandom_range(0, 15);
                default: v = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            endcase
            set_keys(v);
            cur = v;
        end
        run_frames(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
